// File: rtl/alarm_pio_pkg.sv
// Package: alarm_pio_pkg
// Shared constants for the alarm-clock PIO ports.
//  - Avalon register addresses of the button input port.
//  - CAPTURE_EDGE encodings, which select the edges that latch into EDGE_CAP.
//  - qualify_edge(): decides whether one bit's stable-level transition counts as an edge.
package alarm_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_RSVD     = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

   localparam int CAPTURE_PRESS   = 0;
   localparam int CAPTURE_RELEASE = 1;
   localparam int CAPTURE_BOTH    = 2;

   // cur/prev are the debounced level now and one cycle ago (pressed = 1).
   function automatic logic qualify_edge(input logic cur, input logic prev, input int mode);
      logic rise;
      logic fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      case (mode)
         CAPTURE_RELEASE: qualify_edge = fall;
         CAPTURE_BOTH:    qualify_edge = rise | fall;
         default:         qualify_edge = rise;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Module: button_debounce
// One button bit: 2-FF synchroniser, polarity normalisation and a debounce counter.
// Ports:
//  clk      in   system clock
//  reset_n  in   asynchronous, active-low reset
//  pin      in   raw, asynchronous button pin
//  stable   out  debounced level, 1 = pressed
module button_debounce
   import alarm_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic stable
);

   localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic           IDLE_LEVEL = (ACTIVE_LOW != 0);

   logic          sync1;
   logic          sync2;
   logic          sample;
   logic [CW-1:0] cnt;

   // Synchroniser resets to the released pin level so reset alone never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= IDLE_LEVEL;
         sync2 <= IDLE_LEVEL;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // XOR with the idle level turns "pressed" into 1 for either pin polarity.
   assign sample = sync2 ^ IDLE_LEVEL;

   // The counter only runs while the sample disagrees with stable; any agreement wipes it,
   // so a new level must be seen DEBOUNCE_CYCLES times in a row to be accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sample == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= sample;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alarm_button_pio_in.sv
// Module: alarm_button_pio_in
// Avalon-MM slave input port for the alarm-clock push-buttons (set/snooze/stop).
// Debounced levels are latched as sticky edges in EDGE_CAP and raise a maskable level irq.
// Registers: 0 DATA (ro), 1 reserved (reads 0), 2 IRQ_MASK (rw), 3 EDGE_CAP (write-1-to-clear).
// Ports:
//  clk         in   system clock
//  reset_n     in   asynchronous, active-low reset
//  address     in   register select
//  chipselect  in   slave select
//  read_n      in   active-low read strobe
//  write_n     in   active-low write strobe
//  writedata   in   write data, only [WIDTH-1:0] used
//  in_port     in   raw button pins
//  readdata    out  registered read data, latency 1, 0 when not reading
//  irq         out  registered level interrupt
module alarm_button_pio_in
   import alarm_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1,
   parameter int CAPTURE_EDGE    = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] irq_mask;
   logic [31:0]      rd_mux;
   logic             rd_en;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .pin     (in_port[i]),
         .stable  (stable[i])
      );
   end

   assign rd_en = chipselect & ~read_n;
   assign wr_en = chipselect & ~write_n;

   // One-cycle delayed copy of the debounced levels for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d <= '0;
      end else begin
         stable_d <= stable;
      end
   end

   // Edge qualification and the write-1-to-clear vector for EDGE_CAP.
   always_comb begin
      edge_set = '0;
      edge_clr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_set[i] = qualify_edge(stable[i], stable_d[i], CAPTURE_EDGE);
      end
      if (wr_en && (address == ADDR_EDGE_CAP)) begin
         edge_clr = writedata[WIDTH-1:0];
      end
   end

   // The set term is ORed in after the clear so a press landing on a clear is kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
         irq_mask <= '0;
      end else begin
         edge_cap <= (edge_cap & ~edge_clr) | edge_set;
         if (wr_en && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   // Read mux sees the pre-write register values, so a same-cycle read returns old data.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
         ADDR_RSVD:     rd_mux = '0;
         ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
         default:       rd_mux = '0;
      endcase
   end

   // Registered readdata and irq; readdata returns to 0 on cycles without a read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= rd_en ? rd_mux : 32'd0;
         irq      <= |(edge_cap & irq_mask);
      end
   end

endmodule

// File: tb/tb_alarm_button_pio_in.sv
// Testbench: tb_alarm_button_pio_in
// Randomised and directed stimulus against a behavioural model of the button port.
// The model treats a button as accepted once its pressed level has been seen on the
// pin for DEBOUNCE_CYCLES consecutive samples, ending two samples before the current
// edge (synchroniser delay). Expected reads and irq levels go into queues that a
// separate monitor pops on the falling edge.
module tb_alarm_button_pio_in;
   import alarm_pio_pkg::*;

   localparam int W = 4;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          read_n = 1'b1;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '1;
   logic [31:0]   readdata;
   logic          irq;

   int errors = 0;
   int checks = 0;

   logic [31:0]   rd_q[$];
   logic          irq_q[$];

   logic [W-1:0]  pins = '1;

   alarm_button_pio_in #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .ACTIVE_LOW      (1),
      .CAPTURE_EDGE    (CAPTURE_PRESS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One bus cycle plus pin levels, driven on the falling edge.
   task automatic applyStimulus(input logic [1:0] addr, input bit rd, input bit wr,
                                input logic [31:0] wd, input logic [W-1:0] p);
      @(negedge clk);
      address    = addr;
      chipselect = rd | wr;
      read_n     = ~rd;
      write_n    = ~wr;
      writedata  = wd;
      in_port    = p;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(2'd0, 1'b0, 1'b0, 32'd0, pins);
   endtask

   task automatic doRead(input logic [1:0] addr);
      applyStimulus(addr, 1'b1, 1'b0, 32'd0, pins);
   endtask

   task automatic doWrite(input logic [1:0] addr, input logic [31:0] wd);
      applyStimulus(addr, 1'b0, 1'b1, wd, pins);
   endtask

   task automatic pulseReset(input int cycles);
      @(negedge clk);
      #2 reset_n = 1'b0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      #1;
      checkOutput("reset_readdata", readdata, 32'd0);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      repeat (cycles) @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   // ---------------- behavioural reference model ----------------
   bit           m_hist[W][$];
   logic [W-1:0] m_stable;
   logic [W-1:0] m_pend;
   logic [W-1:0] m_cap;
   logic [W-1:0] m_mask;

   task automatic modelReset();
      m_stable = '0;
      m_pend   = '0;
      m_cap    = '0;
      m_mask   = '0;
      for (int i = 0; i < W; i++) begin
         m_hist[i].delete();
         repeat (D + 1) m_hist[i].push_back(1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] clr;
      logic [W-1:0] nxt;
      logic [31:0]  rv;
      bit           held;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            modelReset();
            irq_q.push_back(1'b0);
         end else begin
            if (chipselect && !read_n) begin
               rv = 32'd0;
               case (address)
                  ADDR_DATA:     rv[W-1:0] = m_stable;
                  ADDR_IRQ_MASK: rv[W-1:0] = m_mask;
                  ADDR_EDGE_CAP: rv[W-1:0] = m_cap;
                  default:       rv = 32'd0;
               endcase
               rd_q.push_back(rv);
            end
            irq_q.push_back(|(m_cap & m_mask));
            clr = '0;
            if (chipselect && !write_n && address == ADDR_EDGE_CAP) clr = writedata[W-1:0];
            m_cap = (m_cap & ~clr) | m_pend;
            if (chipselect && !write_n && address == ADDR_IRQ_MASK) m_mask = writedata[W-1:0];
            for (int i = 0; i < W; i++) begin
               // Accept the opposite level only if all D window samples show it.
               held = 1'b1;
               for (int k = 0; k < D; k++) begin
                  if (m_hist[i][k] == m_stable[i]) held = 1'b0;
               end
               nxt[i] = held ? ~m_stable[i] : m_stable[i];
               m_hist[i].push_back(~in_port[i]);
               void'(m_hist[i].pop_front());
            end
            m_pend   = nxt & ~m_stable;
            m_stable = nxt;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rd_q.size() > 0) checkOutput("readdata", readdata, rd_q.pop_front());
         if (irq_q.size() > 0) checkOutput("irq", {31'd0, irq}, {31'd0, irq_q.pop_front()});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int hold[W];
      bit rd;
      bit wr;

      $display("[TB] start");
      pins = '1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_readdata", readdata, 32'd0);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      #1 reset_n = 1'b1;

      // 1: reset values
      doRead(ADDR_DATA);
      doRead(ADDR_IRQ_MASK);
      doRead(ADDR_EDGE_CAP);
      doRead(ADDR_RSVD);
      idle(2);

      // 2: clean press of bit 0
      pins[0] = 1'b0;
      doRead(ADDR_DATA);
      repeat (11) doRead(ADDR_DATA);
      repeat (3) doRead(ADDR_EDGE_CAP);
      idle(2);

      // 3: three 5-cycle glitches on bit 1, then a steady press
      for (int g = 0; g < 3; g++) begin
         pins[1] = 1'b0;
         repeat (5) doRead(ADDR_EDGE_CAP);
         pins[1] = 1'b1;
         repeat (3) doRead(ADDR_EDGE_CAP);
      end
      pins[1] = 1'b0;
      repeat (14) doRead(ADDR_EDGE_CAP);

      // 4: mask, irq, clear
      doWrite(ADDR_EDGE_CAP, 32'h1);
      doWrite(ADDR_IRQ_MASK, 32'h3);
      idle(3);
      doWrite(ADDR_EDGE_CAP, 32'h2);
      idle(2);
      doRead(ADDR_EDGE_CAP);
      idle(2);

      // 5: clear landing on the same edge as a new capture of bit 2
      doWrite(ADDR_IRQ_MASK, 32'h7);
      pins[2] = 1'b0;
      idle(1);
      idle(9);
      doWrite(ADDR_EDGE_CAP, 32'h4);
      doRead(ADDR_EDGE_CAP);
      idle(3);

      // 6: reset mid-debounce with bit 3 held
      pins[3] = 1'b0;
      idle(4);
      pulseReset(3);
      for (int c = 0; c < 14; c++) doRead(c[0] ? ADDR_EDGE_CAP : ADDR_DATA);
      idle(2);

      // random phase
      for (int i = 0; i < W; i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               pins[i] = ~pins[i];
               hold[i] = $urandom_range(1, 16);
            end else begin
               hold[i]--;
            end
         end
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 3) == 0);
         applyStimulus(2'($urandom_range(0, 3)), rd, wr, $urandom, pins);
         if (c == 300) pulseReset(2);
      end
      idle(3);
      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", rd_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
